alu_mul_seq: RTL and testbench

Iterative 64×64→128-bit unsigned multiplier sequencer that drives one instance of the 64-bit `alu` (ADD mode) with a shift-add algorithm, one ALU operation per clock. It sits beside the execute stage and serves MUL/UMULH-class instructions. It gives the pipeline a start/ready/done handshake and holds the result until the next operation is accepted.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 42 ++++
 rtl/alu_mul_seq.sv | 96 +++++++++
 tb/tb_alu_mul_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes and the multiply sequencer state type
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// alu: combinational WIDTH-bit ALU with carry, overflow, sign and zero flags
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             negative,
    output logic             overflow,
    output logic             zero
);

    // Operation select; carry_out is the raw adder carry (no-borrow for subtract)
    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (alu_op_t'(cntrl))
            ALU_PASS_B: result = b;
            ALU_ADD: begin
                {carry_out, result} = {1'b0, a} + {1'b0, b};
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUBTRACT: begin
                {carry_out, result} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign negative = result[WIDTH-1];
    assign zero     = (result == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier driving one ALU in ADD mode
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             zero
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH:0]   addend;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a         (acc_hi_q),
        .b         (m_q),
        .cntrl     (ALU_ADD),
        .result    (sum),
        .carry_out (carry),
        .negative  (),
        .overflow  (),
        .zero      ()
    );

    // Next-state: accept, one shift-add iteration per RUN cycle, single-cycle DONE
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        addend   = acc_lo_q[0] ? {carry, sum} : {1'b0, acc_hi_q};
        case (state_q)
            IDLE: if (start) begin
                m_d      = multiplicand;
                acc_hi_d = '0;
                acc_lo_d = multiplier;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = {addend, acc_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = DONE;
                    zero_d  = ~|{addend, acc_lo_q[WIDTH-1:1]};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign product_hi = acc_hi_q;
    assign product_lo = acc_lo_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized self-checking bench against a 128-bit arithmetic reference
`timescale 1us/1ns
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] multiplicand = '0;
    logic [63:0] multiplier = '0;
    logic        ready;
    logic        done;
    logic [63:0] product_hi;
    logic [63:0] product_lo;
    logic        zero;

    int checks = 0;
    int failures = 0;

    alu_mul_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .zero         (zero)
    );

    // 100 us clock period
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One multiply: optional ignored start pulse at iteration inject_at, optional reset at reset_at
    task automatic run_mul(input logic [63:0] m, input logic [63:0] q, input int inject_at, input int reset_at);
        logic [127:0] exp;
        int lat;
        int dones;
        bit seen;
        exp   = {64'b0, m} * {64'b0, q};
        lat   = 0;
        dones = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
        check("ready_before_start", ready, 1);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (!seen) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
            if (reset_at > 0 && c == reset_at + 1) begin
                check("abort_ready", ready, 1);
                check("abort_product", {product_hi, product_lo}, 128'b0);
                check("abort_zero", zero, 1);
                reset = 1'b1;
            end
            start        = 1'b0;
            multiplicand = {$urandom, $urandom};
            multiplier   = {$urandom, $urandom};
            if (c == inject_at) start = 1'b1;
            if (reset_at > 0 && c == reset_at) reset = 1'b0;
            if (seen && c == lat + 1) begin
                check("done_one_cycle", done, 0);
                check("ready_after_done", ready, 1);
                check("product_held", {product_hi, product_lo}, exp);
                break;
            end
        end
        if (reset_at > 0) begin
            check("no_done_after_abort", dones, 0);
        end else begin
            check("latency", lat, 65);
            check("done_pulses", dones, 1);
            check("product", {product_hi, product_lo}, exp);
            check("zero_flag", zero, exp == 128'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_product", {product_hi, product_lo}, 128'b0);
        check("rst_zero", zero, 1);
        reset = 1'b1;
        run_mul(64'd3, 64'd5, 0, 0);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_mul(64'h8000_0000_0000_0000, 64'd2, 0, 0);
        run_mul(64'd0, 64'h1234, 0, 0);
        run_mul({$urandom, $urandom}, {$urandom, $urandom}, 10, 0);
        run_mul({$urandom, $urandom}, {$urandom, $urandom}, 0, 30);
        run_mul(64'd7, 64'd6, 0, 0);
        for (int i = 0; i < 8; i++)
            run_mul({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 63)), 0);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
